// File: rtl/riscv_decode_stage_if.sv
// Decode-stage boundary: fetch handshake, EX hazard inputs, register-file addresses, decoded output.
// The stage itself uses the slave modport; the fetch/EX side drives through master.
interface riscv_decode_stage_if;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_instr;
  logic [31:0] in_pc;
  logic        flush;
  logic        ex_mem_rd;
  logic [4:0]  ex_rd;
  logic [4:0]  AddrA;
  logic [4:0]  AddrB;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_pc;
  logic [4:0]  out_rs1;
  logic [4:0]  out_rs2;
  logic [4:0]  out_rd;
  logic [31:0] out_imm;
  logic [3:0]  out_opclass;
  logic [2:0]  out_funct3;
  logic        out_funct7b5;
  logic        out_reg_wen;
  logic        out_mem_rd;
  logic        out_mem_wr;
  logic        out_illegal;

  modport slave (
    input  in_valid, in_instr, in_pc, flush, ex_mem_rd, ex_rd, out_ready,
    output in_ready, AddrA, AddrB, out_valid, out_pc, out_rs1, out_rs2, out_rd,
           out_imm, out_opclass, out_funct3, out_funct7b5, out_reg_wen,
           out_mem_rd, out_mem_wr, out_illegal
  );

  modport master (
    output in_valid, in_instr, in_pc, flush, ex_mem_rd, ex_rd, out_ready,
    input  in_ready, AddrA, AddrB, out_valid, out_pc, out_rs1, out_rs2, out_rd,
           out_imm, out_opclass, out_funct3, out_funct7b5, out_reg_wen,
           out_mem_rd, out_mem_wr, out_illegal
  );
endinterface

// File: rtl/riscv_decode_stage.sv
// RV32I decode stage: one-cycle registered decode with load-use bubbles and flush.
// Latency 1 cycle; out_valid && !out_ready holds the register and re-presents its read addresses.
module riscv_decode_stage #(
  parameter int XLEN = 32
) (
  input logic                  clk,
  input logic                  rst_n,
  riscv_decode_stage_if.slave  bus
);

  typedef enum logic [3:0] {
    OC_LUI    = 4'd0,
    OC_AUIPC  = 4'd1,
    OC_JAL    = 4'd2,
    OC_JALR   = 4'd3,
    OC_BRANCH = 4'd4,
    OC_LOAD   = 4'd5,
    OC_STORE  = 4'd6,
    OC_OPIMM  = 4'd7,
    OC_OP     = 4'd8,
    OC_ILL    = 4'd15
  } opclass_e;

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [4:0]      rs1;
    logic [4:0]      rs2;
    logic [4:0]      rd;
    logic [XLEN-1:0] imm;
    opclass_e        opclass;
    logic [2:0]      funct3;
    logic            funct7b5;
    logic            reg_wen;
    logic            mem_rd;
    logic            mem_wr;
    logic            illegal;
  } dec_t;

  logic [31:0] instr;
  logic [6:0]  opcode;
  logic [31:0] imm_i, imm_s, imm_b, imm_u, imm_j;
  logic        use_rs1, use_rs2, wen_cls;
  logic        hold, hazard;
  dec_t        dec;
  dec_t        out_d, out_q;
  logic        out_valid_d, out_valid_q;

  assign instr  = bus.in_instr;
  assign opcode = instr[6:0];
  assign imm_i  = {{20{instr[31]}}, instr[31:20]};
  assign imm_s  = {{20{instr[31]}}, instr[31:25], instr[11:7]};
  assign imm_b  = {{19{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
  assign imm_u  = {instr[31:12], 12'b0};
  assign imm_j  = {{11{instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};

  always_comb begin
    dec          = '0;
    dec.pc       = bus.in_pc;
    dec.rs1      = instr[19:15];
    dec.rs2      = instr[24:20];
    dec.rd       = instr[11:7];
    dec.funct3   = instr[14:12];
    dec.funct7b5 = instr[30];
    dec.opclass  = OC_ILL;
    dec.illegal  = 1'b1;
    dec.imm      = '0;
    use_rs1      = 1'b0;
    use_rs2      = 1'b0;
    wen_cls      = 1'b0;
    case (opcode)
      7'b0110111: begin dec.opclass = OC_LUI;    dec.illegal = 1'b0; dec.imm = imm_u; wen_cls = 1'b1; end
      7'b0010111: begin dec.opclass = OC_AUIPC;  dec.illegal = 1'b0; dec.imm = imm_u; wen_cls = 1'b1; end
      7'b1101111: begin dec.opclass = OC_JAL;    dec.illegal = 1'b0; dec.imm = imm_j; wen_cls = 1'b1; end
      7'b1100111: begin dec.opclass = OC_JALR;   dec.illegal = 1'b0; dec.imm = imm_i; wen_cls = 1'b1;
                        use_rs1 = 1'b1; end
      7'b1100011: begin dec.opclass = OC_BRANCH; dec.illegal = 1'b0; dec.imm = imm_b;
                        use_rs1 = 1'b1; use_rs2 = 1'b1; end
      7'b0000011: begin dec.opclass = OC_LOAD;   dec.illegal = 1'b0; dec.imm = imm_i; wen_cls = 1'b1;
                        use_rs1 = 1'b1; dec.mem_rd = 1'b1; end
      7'b0100011: begin dec.opclass = OC_STORE;  dec.illegal = 1'b0; dec.imm = imm_s;
                        use_rs1 = 1'b1; use_rs2 = 1'b1; dec.mem_wr = 1'b1; end
      7'b0010011: begin dec.opclass = OC_OPIMM;  dec.illegal = 1'b0; dec.imm = imm_i; wen_cls = 1'b1;
                        use_rs1 = 1'b1; end
      7'b0110011: begin dec.opclass = OC_OP;     dec.illegal = 1'b0; wen_cls = 1'b1;
                        use_rs1 = 1'b1; use_rs2 = 1'b1; end
      default: ;
    endcase
    // Writes to x0 are architecturally dropped, so never advertise them downstream.
    dec.reg_wen = wen_cls && (dec.rd != 5'd0);
  end

  assign hold   = out_valid_q && !bus.out_ready;
  assign hazard = bus.in_valid && bus.ex_mem_rd && (bus.ex_rd != 5'd0) &&
                  ((use_rs1 && (bus.ex_rd == dec.rs1)) || (use_rs2 && (bus.ex_rd == dec.rs2)));

  assign bus.in_ready = bus.flush || (!hold && !hazard);

  // While held, keep reading the held instruction's sources so operand data stays aligned with out_*.
  assign bus.AddrA = hold ? out_q.rs1 : dec.rs1;
  assign bus.AddrB = hold ? out_q.rs2 : dec.rs2;

  always_comb begin
    out_d       = out_q;
    out_valid_d = out_valid_q;
    if (bus.flush) begin
      out_valid_d = 1'b0;
    end else if (!hold) begin
      if (bus.in_valid && !hazard) begin
        out_d       = dec;
        out_valid_d = 1'b1;
      end else begin
        out_valid_d = 1'b0;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_q       <= '0;
      out_valid_q <= 1'b0;
    end else begin
      out_q       <= out_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign bus.out_valid    = out_valid_q;
  assign bus.out_pc       = out_q.pc;
  assign bus.out_rs1      = out_q.rs1;
  assign bus.out_rs2      = out_q.rs2;
  assign bus.out_rd       = out_q.rd;
  assign bus.out_imm      = out_q.imm;
  assign bus.out_opclass  = out_q.opclass;
  assign bus.out_funct3   = out_q.funct3;
  assign bus.out_funct7b5 = out_q.funct7b5;
  assign bus.out_reg_wen  = out_q.reg_wen;
  assign bus.out_mem_rd   = out_q.mem_rd;
  assign bus.out_mem_wr   = out_q.mem_wr;
  assign bus.out_illegal  = out_q.illegal;

endmodule

// File: tb/tb_riscv_decode_stage.sv
// Directed bench for riscv_decode_stage: hand-encoded RV32I words with hand-computed decode results.
module tb_riscv_decode_stage;

  localparam logic [31:0] I_ADDI = 32'hFFD08293; // addi x5,x1,-3
  localparam logic [31:0] I_SW   = 32'h0021A423; // sw x2,8(x3)
  localparam logic [31:0] I_NOP  = 32'h00000013; // addi x0,x0,0
  localparam logic [31:0] I_LUI  = 32'h123453B7; // lui x7,0x12345
  localparam logic [31:0] I_BEQ  = 32'hFE208EE3; // beq x1,x2,-4
  localparam logic [31:0] I_JAL  = 32'h008000EF; // jal x1,8

  logic clk;
  logic rst_n;
  int   n_checks;
  int   n_fail;

  riscv_decode_stage_if dif ();

  riscv_decode_stage #(.XLEN(32)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (dif)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic present(input logic [31:0] instr, input logic [31:0] pc);
    dif.in_valid = 1'b1;
    dif.in_instr = instr;
    dif.in_pc    = pc;
    #1;
  endtask

  initial begin
    n_checks      = 0;
    n_fail        = 0;
    rst_n         = 1'b0;
    dif.in_valid  = 1'b0;
    dif.in_instr  = 32'h0;
    dif.in_pc     = 32'h0;
    dif.flush     = 1'b0;
    dif.ex_mem_rd = 1'b0;
    dif.ex_rd     = 5'd0;
    dif.out_ready = 1'b1;

    #12;
    chk_val("rst_out_valid", 32'(dif.out_valid), 32'd0);
    chk_val("rst_out_imm",   dif.out_imm,        32'd0);
    chk_val("rst_out_pc",    dif.out_pc,         32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    tick();

    // Basic ADDI
    present(I_ADDI, 32'h100);
    chk_val("addi_in_ready", 32'(dif.in_ready), 32'd1);
    chk_val("addi_AddrA",    32'(dif.AddrA),    32'd1);
    tick();
    chk_val("addi_out_valid", 32'(dif.out_valid),   32'd1);
    chk_val("addi_rd",        32'(dif.out_rd),      32'd5);
    chk_val("addi_rs1",       32'(dif.out_rs1),     32'd1);
    chk_val("addi_imm",       dif.out_imm,          32'hFFFFFFFD);
    chk_val("addi_opclass",   32'(dif.out_opclass), 32'd7);
    chk_val("addi_reg_wen",   32'(dif.out_reg_wen), 32'd1);
    chk_val("addi_pc",        dif.out_pc,           32'h100);

    // Store, back-to-back
    present(I_SW, 32'h104);
    chk_val("sw_AddrA", 32'(dif.AddrA), 32'd3);
    chk_val("sw_AddrB", 32'(dif.AddrB), 32'd2);
    tick();
    chk_val("sw_out_valid", 32'(dif.out_valid),   32'd1);
    chk_val("sw_imm",       dif.out_imm,          32'd8);
    chk_val("sw_opclass",   32'(dif.out_opclass), 32'd6);
    chk_val("sw_mem_wr",    32'(dif.out_mem_wr),  32'd1);
    chk_val("sw_reg_wen",   32'(dif.out_reg_wen), 32'd0);
    chk_val("sw_funct3",    32'(dif.out_funct3),  32'd2);

    // Load-use on rs1: two stalled cycles, each producing a bubble
    dif.ex_mem_rd = 1'b1;
    dif.ex_rd     = 5'd1;
    present(I_ADDI, 32'h108);
    chk_val("lu_in_ready_0", 32'(dif.in_ready), 32'd0);
    tick();
    chk_val("lu_bubble_0", 32'(dif.out_valid), 32'd0);
    chk_val("lu_in_ready_1", 32'(dif.in_ready), 32'd0);
    tick();
    chk_val("lu_bubble_1", 32'(dif.out_valid), 32'd0);
    dif.ex_mem_rd = 1'b0;
    #1;
    chk_val("lu_release_ready", 32'(dif.in_ready), 32'd1);
    tick();
    chk_val("lu_accept_valid", 32'(dif.out_valid), 32'd1);
    chk_val("lu_accept_pc",    dif.out_pc,         32'h108);

    // ex_rd = x0 never stalls; ADDI's rs2 field (x29) is not a source
    dif.ex_mem_rd = 1'b1;
    dif.ex_rd     = 5'd0;
    present(I_ADDI, 32'h10C);
    chk_val("lu_x0_ready", 32'(dif.in_ready), 32'd1);
    dif.ex_rd = 5'd29;
    #1;
    chk_val("lu_unused_rs2_ready", 32'(dif.in_ready), 32'd1);
    dif.ex_rd = 5'd2;
    present(I_SW, 32'h10C);
    chk_val("lu_store_rs2_ready", 32'(dif.in_ready), 32'd0);
    dif.ex_mem_rd = 1'b0;
    dif.ex_rd     = 5'd0;

    // Backpressure: capture ADDI, then hold it for 3 cycles with SW waiting
    present(I_ADDI, 32'h110);
    tick();
    chk_val("bp_cap_valid", 32'(dif.out_valid), 32'd1);
    dif.out_ready = 1'b0;
    present(I_SW, 32'h114);
    for (int i = 0; i < 3; i++) begin
      chk_val("bp_in_ready", 32'(dif.in_ready), 32'd0);
      chk_val("bp_AddrA",    32'(dif.AddrA),    32'd1);
      chk_val("bp_AddrB",    32'(dif.AddrB),    32'd29);
      tick();
      chk_val("bp_valid", 32'(dif.out_valid), 32'd1);
      chk_val("bp_pc",    dif.out_pc,         32'h110);
      chk_val("bp_imm",   dif.out_imm,        32'hFFFFFFFD);
    end
    dif.out_ready = 1'b1;
    #1;
    chk_val("bp_release_ready", 32'(dif.in_ready), 32'd1);
    chk_val("bp_release_AddrA", 32'(dif.AddrA),    32'd3);
    tick();
    chk_val("bp_next_pc",      dif.out_pc,           32'h114);
    chk_val("bp_next_opclass", 32'(dif.out_opclass), 32'd6);

    // Flush overrides hold and discards the incoming instruction
    dif.out_ready = 1'b0;
    dif.flush     = 1'b1;
    present(I_LUI, 32'h118);
    chk_val("flush_in_ready", 32'(dif.in_ready), 32'd1);
    tick();
    chk_val("flush_out_valid", 32'(dif.out_valid), 32'd0);
    dif.flush     = 1'b0;
    dif.out_ready = 1'b1;

    // Opcode and immediate corner cases
    present(32'h00000000, 32'h200);
    tick();
    chk_val("ill_valid",   32'(dif.out_valid),   32'd1);
    chk_val("ill_illegal", 32'(dif.out_illegal), 32'd1);
    chk_val("ill_opclass", 32'(dif.out_opclass), 32'd15);
    chk_val("ill_reg_wen", 32'(dif.out_reg_wen), 32'd0);
    chk_val("ill_imm",     dif.out_imm,          32'd0);

    present(I_NOP, 32'h204);
    tick();
    chk_val("nop_opclass", 32'(dif.out_opclass), 32'd7);
    chk_val("nop_reg_wen", 32'(dif.out_reg_wen), 32'd0);
    chk_val("nop_illegal", 32'(dif.out_illegal), 32'd0);

    present(I_LUI, 32'h208);
    tick();
    chk_val("lui_imm",     dif.out_imm,          32'h12345000);
    chk_val("lui_reg_wen", 32'(dif.out_reg_wen), 32'd1);
    chk_val("lui_opclass", 32'(dif.out_opclass), 32'd0);
    chk_val("lui_rd",      32'(dif.out_rd),      32'd7);

    present(I_BEQ, 32'h20C);
    tick();
    chk_val("beq_imm",     dif.out_imm,          32'hFFFFFFFC);
    chk_val("beq_opclass", 32'(dif.out_opclass), 32'd4);
    chk_val("beq_reg_wen", 32'(dif.out_reg_wen), 32'd0);

    present(I_JAL, 32'h210);
    tick();
    chk_val("jal_imm",     dif.out_imm,          32'd8);
    chk_val("jal_opclass", 32'(dif.out_opclass), 32'd2);
    chk_val("jal_reg_wen", 32'(dif.out_reg_wen), 32'd1);

    // No input -> bubble
    dif.in_valid = 1'b0;
    tick();
    chk_val("idle_bubble", 32'(dif.out_valid), 32'd0);

    // Asynchronous reset mid-stream
    present(I_ADDI, 32'h300);
    tick();
    chk_val("pre_rst_valid", 32'(dif.out_valid), 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    chk_val("async_rst_valid", 32'(dif.out_valid), 32'd0);
    chk_val("async_rst_pc",    dif.out_pc,         32'd0);
    chk_val("async_rst_imm",   dif.out_imm,        32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    chk_val("post_rst_valid", 32'(dif.out_valid), 32'd1);
    chk_val("post_rst_pc",    dif.out_pc,         32'h300);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/riscv_decode_stage.md
Name: riscv_decode_stage

Overview:
- RV32I decode stage, directly upstream of the register file.
- Drives register-file read addresses AddrA/AddrB and holds a decoded instruction in a valid/ready pipeline register for EX.
- Register-file reads are registered on posedge clk, so DataA/DataB arrive one cycle after the address is presented. That is the same cycle the decoded fields appear on out_*, so operands and control stay aligned.
- Detects load-use hazards against EX and inserts bubbles. Supports flush.

Parameters:
- XLEN, 32, datapath width; only 32 is supported.

Ports:
- clk  in  1  clock, posedge.
- rst_n  in  1  asynchronous, active-low reset.
- in_valid  in  1  fetch presents an instruction.
- in_ready  out  1  stage accepts an instruction this cycle.
- in_instr  in  32  instruction word; held stable by upstream while in_valid && !in_ready.
- in_pc  in  32  PC of in_instr.
- flush  in  1  discard held and incoming instruction.
- ex_mem_rd  in  1  instruction in EX is a load.
- ex_rd  in  5  destination of the instruction in EX.
- AddrA  out  5  register-file read address A.
- AddrB  out  5  register-file read address B.
- out_valid  out  1  decoded instruction valid.
- out_ready  in  1  EX accepts the instruction.
- out_pc  out  32  PC.
- out_rs1, out_rs2, out_rd  out  5 each  register fields, for forwarding.
- out_imm  out  32  sign-extended immediate.
- out_opclass  out  4  0 LUI, 1 AUIPC, 2 JAL, 3 JALR, 4 BRANCH, 5 LOAD, 6 STORE, 7 OP-IMM, 8 OP, 15 illegal.
- out_funct3  out  3  instr[14:12].
- out_funct7b5  out  1  instr[30].
- out_reg_wen  out  1  drives RegWEn downstream.
- out_mem_rd, out_mem_wr  out  1 each  load / store.
- out_illegal  out  1  unsupported opcode.

Behaviour:
- Reset (async, rst_n=0): out_valid=0 and every out_* register = 0, effective immediately. First capture is on the first posedge after rst_n rises.
- Opcode decode (instr[6:0]):
  - 0110111 LUI, 0010111 AUIPC, 1101111 JAL, 1100111 JALR, 1100011 BRANCH, 0000011 LOAD, 0100011 STORE, 0010011 OP-IMM, 0110011 OP.
  - Any other opcode is illegal: opclass=15, out_illegal=1, imm=0, reg_wen=0, mem_rd=0, mem_wr=0.
- Immediates, sign bit instr[31]:
  - I-type (JALR, LOAD, OP-IMM): instr[31:20].
  - S-type: {[31:25],[11:7]}.
  - B-type: {[31],[7],[30:25],[11:8],0}.
  - U-type: {[31:12],12'b0}.
  - J-type: {[31],[19:12],[20],[30:21],0}.
  - OP: imm=0.
- Register usage:
  - use_rs1 for every legal class except LUI, AUIPC, JAL.
  - use_rs2 for BRANCH, STORE, OP.
  - reg_wen=1 for LUI, AUIPC, JAL, JALR, LOAD, OP-IMM, OP, and only when rd!=0.
- Control signals (combinational):
  - hold = out_valid && !out_ready.
  - hazard = in_valid && ex_mem_rd && ex_rd!=0 && ((use_rs1 && ex_rd==rs1) || (use_rs2 && ex_rd==rs2)).
  - in_ready = flush || (!hold && !hazard).
- Read addresses:
  - AddrA/AddrB = hold ? out_rs1/out_rs2 : in_instr[19:15]/[24:20].
  - During hold the register file re-reads the same registers every cycle. This also picks up negedge writebacks.
- Pipeline register update on posedge, in priority order:
  1. flush: out_valid<=0; any input that cycle is consumed and discarded.
  2. hold: all out_* unchanged.
  3. in_valid && !hazard: capture the decoded instruction, out_valid<=1.
  4. Otherwise (bubble or no input): out_valid<=0; other out_* are don't-care but stay registered.
- Latency: 1 cycle from acceptance to out_valid. Throughput: 1 instruction per cycle with no hazard or backpressure.
- Hazard persists as long as the EX inputs assert it; one bubble is inserted per stalled cycle.
- No combinational path from out_ready to out_* data. in_ready depends combinationally on out_ready, flush, ex_* and in_instr.

Test Plan:
- ADDI x5,x1,-3 (0xFFD08293), in_valid=1, out_ready=1 -> AddrA=1 in the accept cycle; next cycle out_valid=1, out_rd=5, out_rs1=1, out_imm=0xFFFFFFFD, opclass=7, reg_wen=1.
- SW x2,8(x3) (0x0021A423) -> AddrA=3, AddrB=2; out_imm=8, opclass=6, mem_wr=1, reg_wen=0.
- Load-use: ex_mem_rd=1, ex_rd=1 with ADDI x5,x1 held -> in_ready=0, out_valid=0 next cycle. Drop ex_mem_rd -> accepted, out_valid=1. Repeat with ex_rd=0 -> no stall.
- Backpressure: out_ready=0 for 3 cycles after a capture -> out_* stable, AddrA=out_rs1, in_ready=0. Raise out_ready -> next instruction captured the following cycle.
- Flush with out_valid=1 and a new valid input -> in_ready=1, out_valid=0 next cycle. Separately, rst_n=0 mid-stream -> out_valid=0 without waiting for a clock.
- in_instr=0x00000000 -> out_illegal=1, opclass=15, reg_wen=0. ADDI x0,x0,0 (0x00000013) -> reg_wen=0. LUI x7,0x12345 (0x123453B7) -> imm=0x12345000, reg_wen=1.
